// File: rtl/led_frame_serializer.sv
// Serialises an 8x8 staged frame MSB-first with a bit clock, then strobes ser_latch.
// Optional SERIALIZER_AUTO_REPEAT_EN: start is level-sensitive and frames repeat back-to-back.
module led_frame_serializer #(
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       ser_data,
  output logic       ser_clk,
  output logic       ser_latch
);

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] LATCH_LAST = 8'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LATCH} state_t;

  state_t      state, state_nxt;
  logic [63:0] staging, staging_nxt;
  logic [63:0] shift_reg, shift_nxt;
  logic [5:0]  bit_cnt, bit_nxt;
  logic [7:0]  div_cnt, div_nxt;
  logic        start_prev;
  logic        start_req;
  logic        done_nxt;

`ifdef SERIALIZER_AUTO_REPEAT_EN
  assign start_req = start;
`else
  assign start_req = start & ~start_prev;
`endif

  // Write-first view of the staging buffer so a same-cycle write reaches the loaded frame.
  always_comb begin
    staging_nxt = staging;
    if (wr_en) staging_nxt[{wr_addr, 3'b000} +: 8] = wr_data;
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    bit_nxt   = bit_cnt;
    div_nxt   = div_cnt + 8'd1;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        div_nxt = '0;
        if (start_req) begin
          state_nxt = SETUP;
          shift_nxt = staging_nxt;
          bit_nxt   = '0;
        end
      end
      SETUP: begin
        if (div_cnt == DIV_LAST) begin
          state_nxt = HIGH;
          div_nxt   = '0;
        end
      end
      HIGH: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt   = '0;
          shift_nxt = {shift_reg[62:0], 1'b0};
          bit_nxt   = bit_cnt + 6'd1;
          state_nxt = (bit_cnt == 6'd63) ? LATCH : SETUP;
        end
      end
      LATCH: begin
        if (div_cnt == LATCH_LAST) begin
          div_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
`ifdef SERIALIZER_AUTO_REPEAT_EN
          if (start) begin
            state_nxt = SETUP;
            shift_nxt = staging_nxt;
            bit_nxt   = '0;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output leaves a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      staging    <= '0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      start_prev <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ser_data   <= 1'b0;
      ser_clk    <= 1'b0;
      ser_latch  <= 1'b0;
    end else begin
      state      <= state_nxt;
      staging    <= staging_nxt;
      shift_reg  <= shift_nxt;
      bit_cnt    <= bit_nxt;
      div_cnt    <= div_nxt;
      start_prev <= start;
      busy       <= (state_nxt != IDLE);
      done       <= done_nxt;
      ser_clk    <= (state_nxt == HIGH);
      ser_latch  <= (state_nxt == LATCH);
      ser_data   <= ((state_nxt == SETUP) || (state_nxt == HIGH)) ? shift_nxt[63] : 1'b0;
    end
  end

endmodule

// File: tb/tb_led_frame_serializer.sv
// Bench for led_frame_serializer: two instances (CLK_DIV 1 and 4) share stimulus; a chain model
// captures each frame at the latch and is scored against expected frames queued at start.
module tb_led_frame_serializer;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] start_v;
  logic [1:0] busy_v, done_v, sdat_v, sclk_v, slat_v;

  always #5 clk = ~clk;

  led_frame_serializer #(.CLK_DIV(1), .LATCH_CYCLES(LAT)) u_fast (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]), .ser_data(sdat_v[0]),
    .ser_clk(sclk_v[0]), .ser_latch(slat_v[0]));

  led_frame_serializer #(.CLK_DIV(4), .LATCH_CYCLES(LAT)) u_slow (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]), .ser_data(sdat_v[1]),
    .ser_clk(sclk_v[1]), .ser_latch(slat_v[1]));

  typedef struct {
    logic [63:0] img;
    logic        byp;
    logic [2:0]  baddr;
    logic [7:0]  bdata;
    logic [63:0] exp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] stg;
  int          acc[2], pushed[2], dcnt[2], bcyc[2], rises[2], lcyc[2], lrise[2], terr[2];
  int          latch_seen[2];
  logic [63:0] chain[2], latched[2];
  logic        pclk[2], plat[2], pdat[2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int divof(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic pop_exp(input int i, output logic [63:0] f, output logic more);
    f    = '0;
    more = 1'b0;
    if (i == 0) begin
      if (q0.size() == 0) return 1'b0;
      f    = q0.pop_front();
      more = (q0.size() != 0);
    end else begin
      if (q1.size() == 0) return 1'b0;
      f    = q1.pop_front();
      more = (q1.size() != 0);
    end
    return 1'b1;
  endfunction

  task automatic push_exp(input int i, input logic [63:0] f);
    if (i == 0) q0.push_back(f);
    else        q1.push_back(f);
    pushed[i]++;
    acc[i] = cyc;
  endtask

  task automatic mon_step(input int i);
    int          d, rel;
    logic [63:0] f;
    logic        more, ok;
    d   = divof(i);
    rel = cyc - acc[i];
    if (busy_v[i]) bcyc[i]++;
    if (sclk_v[i] && pclk[i] && (sdat_v[i] != pdat[i])) terr[i]++;
    if (sclk_v[i] && !pclk[i]) begin
      chain[i] = {chain[i][62:0], sdat_v[i]};
      if (rel != 1 + (2 * rises[i] + 1) * d) terr[i]++;
      rises[i]++;
    end
    if (slat_v[i]) begin
      if (!plat[i]) begin
        lrise[i]   = rel;
        latched[i] = chain[i];
      end
      lcyc[i]++;
      latch_seen[i]++;
    end
    if (done_v[i]) begin
      dcnt[i]++;
      ok = pop_exp(i, f, more);
      if (!ok) begin
        chk($sformatf("unexpected_done[%0d]", i), 64'd1, 64'd0);
      end else begin
        chk($sformatf("frame[%0d]", i), latched[i], f);
        chk($sformatf("done_latency[%0d]", i), 64'(rel), 64'(128 * d + LAT + 1));
        chk($sformatf("busy_at_done[%0d]", i), 64'(busy_v[i]), 64'(more));
        chk($sformatf("busy_cycles[%0d]", i), 64'(bcyc[i]), 64'(128 * d + LAT + int'(more)));
        chk($sformatf("clk_rises[%0d]", i), 64'(rises[i]), 64'd64);
        chk($sformatf("latch_cycles[%0d]", i), 64'(lcyc[i]), 64'(LAT));
        chk($sformatf("latch_start[%0d]", i), 64'(lrise[i]), 64'(128 * d + 1));
        chk($sformatf("bit_timing_errs[%0d]", i), 64'(terr[i]), 64'd0);
      end
      if (busy_v[i]) acc[i] = cyc - 1;
      bcyc[i]  = busy_v[i] ? 1 : 0;
      rises[i] = 0;
      lcyc[i]  = 0;
      terr[i]  = 0;
    end
    pclk[i] = sclk_v[i];
    plat[i] = slat_v[i];
    pdat[i] = sdat_v[i];
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        bcyc[i] = 0; rises[i] = 0; lcyc[i] = 0; terr[i] = 0; lrise[i] = 0;
        pclk[i] = 1'b0; plat[i] = 1'b0; pdat[i] = 1'b0;
      end else begin
        mon_step(i);
      end
    end
  end

  task automatic write_col(input logic [2:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    stg[8 * a +: 8] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] m, input logic byp, input logic [2:0] a,
                             input logic [7:0] d, input logic [63:0] f, input logic hold);
    start_v = m;
    if (byp) begin
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      stg[8 * a +: 8] = d;
    end
    if (m[0]) push_exp(0, f);
    if (m[1]) push_exp(1, f);
    @(negedge clk);
    if (!hold) start_v = 2'b00;
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(dcnt[0] == pushed[0] && dcnt[1] == pushed[1] && busy_v == 2'b00) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  vec_t tbl[6];

  initial begin
    int cnt;
    tbl[0] = '{64'h8040201008040201, 1'b0, 3'd0, 8'h00, 64'h8040201008040201};
    tbl[1] = '{64'hAAAAAAAAAAAAAAAA, 1'b0, 3'd0, 8'h00, 64'hAAAAAAAAAAAAAAAA};
    tbl[2] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 3'd0, 8'h5A, 64'hFFFFFFFFFFFFFF5A};
    tbl[3] = '{64'h0123456789ABCDEF, 1'b1, 3'd7, 8'h00, 64'h0023456789ABCDEF};
    tbl[4] = '{64'h0000000000000000, 1'b1, 3'd3, 8'h3C, 64'h000000003C000000};
    tbl[5] = '{64'h00000000000000C3, 1'b0, 3'd0, 8'h00, 64'h00000000000000C3};
    for (int i = 0; i < 2; i++) begin
      acc[i] = 0; pushed[i] = 0; dcnt[i] = 0; latch_seen[i] = 0; chain[i] = '0; latched[i] = '0;
    end
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start_v = '0; stg = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_outs[%0d]", i),
          64'({busy_v[i], done_v[i], sdat_v[i], sclk_v[i], slat_v[i]}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      for (int c = 0; c < 8; c++) write_col(3'(c), tbl[v].img[8 * c +: 8]);
      start_frame(2'b11, tbl[v].byp, tbl[v].baddr, tbl[v].bdata, tbl[v].exp, 1'b0);
      wait_idle(3000);
    end

    // Start edge while busy is dropped; the mid-frame column-7 write only shows in the next frame.
    start_frame(2'b11, 1'b0, 3'd0, 8'h00, stg, 1'b0);
    repeat (20) @(negedge clk);
    start_v = 2'b11; wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'hFF; stg[63:56] = 8'hFF;
    @(negedge clk);
    start_v = 2'b00; wr_en = 1'b0;
    wait_idle(3000);
    repeat (30) @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("single_done[%0d]", i), 64'(dcnt[i]), 64'(pushed[i]));
    start_frame(2'b11, 1'b0, 3'd0, 8'h00, stg, 1'b0);
    wait_idle(3000);

`ifdef SERIALIZER_AUTO_REPEAT_EN
    for (int i = 0; i < 2; i++) begin
      int gaps, n;
      gaps = 0; n = 0;
      start_frame(2'b01 << i, 1'b0, 3'd0, 8'h00, stg, 1'b1);
      push_exp(i, stg);
      push_exp(i, stg);
      acc[i] = cyc - 1;
      while (dcnt[i] < pushed[i] - 1 && n < 3000) begin
        if (!busy_v[i]) gaps++;
        @(negedge clk); n++;
      end
      repeat (10) begin
        if (!busy_v[i]) gaps++;
        @(negedge clk);
      end
      start_v = 2'b00;
      while (dcnt[i] < pushed[i] && n < 6000) begin
        if (!busy_v[i] && !done_v[i]) gaps++;
        @(negedge clk); n++;
      end
      chk($sformatf("repeat_busy_gaps[%0d]", i), 64'(gaps), 64'd0);
      wait_idle(3000);
      repeat (20) @(negedge clk);
      chk($sformatf("repeat_stops[%0d]", i), 64'(busy_v[i]), 64'd0);
    end
`else
    start_frame(2'b11, 1'b0, 3'd0, 8'h00, stg, 1'b1);
    wait_idle(3000);
    cnt = 0;
    repeat (600) begin
      @(negedge clk);
      if (busy_v != 2'b00) cnt++;
    end
    start_v = 2'b00;
    chk("level_start_no_repeat", 64'(cnt), 64'd0);
`endif

    // Asynchronous reset mid-frame: outputs clear at once, no latch, staging cleared.
    start_frame(2'b11, 1'b0, 3'd0, 8'h00, stg, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("async_reset_outs[%0d]", i),
          64'({busy_v[i], done_v[i], sdat_v[i], sclk_v[i], slat_v[i]}), 64'd0);
    q0.delete(); q1.delete();
    stg = '0;
    for (int i = 0; i < 2; i++) pushed[i] = dcnt[i];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    latch_seen[0] = 0; latch_seen[1] = 0;
    cnt = 0;
    repeat (600) begin
      @(negedge clk);
      if (busy_v != 2'b00) cnt++;
    end
    chk("busy_after_reset", 64'(cnt), 64'd0);
    for (int i = 0; i < 2; i++)
      chk($sformatf("latch_after_reset[%0d]", i), 64'(latch_seen[i]), 64'd0);
    start_frame(2'b11, 1'b0, 3'd0, 8'h00, stg, 1'b0);
    wait_idle(3000);

    for (int i = 0; i < 2; i++)
      chk($sformatf("frames_done[%0d]", i), 64'(dcnt[i]), 64'(pushed[i]));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
